// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, synchronous-read word memory between the
// instruction-fetch path (IF) and the load/store path (LS). LS has fixed
// priority; a wait counter forces an IF grant after MAX_WAIT consecutive LS
// wins while IF is waiting. Each access takes an issue cycle (IDLE) and a
// response cycle (RESP_*), so the peak rate is one access every two cycles.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,  // must be 32: one enable per byte lane
  parameter int unsigned MEM_AW     = 8,
  parameter int unsigned MAX_WAIT   = 3    // must be >= 1
) (
  input  logic                  clk,
  input  logic                  nreset,
  // Instruction-fetch requester
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  // Load/store requester
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  input  logic [3:0]            ls_be,
  output logic                  ls_ack,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  // Memory port
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  // Debug
  output logic [1:0]            grant_owner
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] MaxWait = WaitW'(MAX_WAIT);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRespIf = 2'b01,
    StRespLs = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] if_wait_q, if_wait_d;

  logic ls_win;
  logic if_win;
  logic issue;

  // Only the word-address bits reach the memory; the rest wrap or are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[ADDR_WIDTH-1:MEM_AW+2], if_addr[1:0],
                              ls_addr[ADDR_WIDTH-1:MEM_AW+2], ls_addr[1:0]};

  // Winner selection; only acted on in IDLE.
  always_comb begin
    ls_win = ls_req && (!if_req || (if_wait_q < MaxWait));
    if_win = if_req && !ls_win;
  end

  // State register and IF wait counter.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= StIdle;
      if_wait_q <= '0;
    end else begin
      state_q   <= state_d;
      if_wait_q <= if_wait_d;
    end
  end

  // Next-state: IDLE issues to the winner, every RESP returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (ls_win) begin
          state_d = StRespLs;
        end else if (if_win) begin
          state_d = StRespIf;
        end
      end
      StRespIf: state_d = StIdle;
      StRespLs: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Wait counter: counts LS wins that IF sat out, saturating at MAX_WAIT.
  always_comb begin
    if_wait_d = if_wait_q;
    if (!if_req) begin
      if_wait_d = '0;
    end else if (state_q == StIdle) begin
      if (if_win) begin
        if_wait_d = '0;
      end else if (ls_win && (if_wait_q != MaxWait)) begin
        if_wait_d = if_wait_q + 1'b1;
      end
    end
  end

  // Memory-side outputs; reset gating keeps the strobes low while nreset is held.
  always_comb begin
    issue     = (state_q == StIdle) && nreset && (ls_win || if_win);
    mem_en    = issue;
    mem_we    = issue && ls_win && ls_we;
    mem_addr  = ls_win ? ls_addr[MEM_AW+1:2] : if_addr[MEM_AW+1:2];
    mem_wdata = ls_win ? ls_wdata : '0;
    mem_be    = (ls_win && ls_we) ? ls_be : 4'b1111;
  end

  // Requester-side outputs decoded from the response state.
  always_comb begin
    if_ack      = (state_q == StRespIf);
    ls_ack      = (state_q == StRespLs);
    if_rdata    = mem_rdata;
    ls_rdata    = mem_rdata;
    grant_owner = 2'b00;
    case (state_q)
      StRespIf: grant_owner = 2'b01;
      StRespLs: grant_owner = 2'b10;
      default:  grant_owner = 2'b00;
    endcase
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read word memory between the CPU instruction-fetch path (IF) and the load/store path (LS).
- Replaces direct `code_mem[pc[..:2]]` indexing once LDR/STR are enabled.
- Sits between the cpu core and a unified code/data RAM.
- Uses fixed priority to LS, with a starvation guard that forces an IF grant after MAX_WAIT consecutive LS wins.

Parameters:
ADDR_WIDTH, 32, width of the byte addresses presented by requesters
DATA_WIDTH, 32, memory word width; must be 32 (4 byte enables)
MEM_AW, 8, memory word-address width; mem_addr = addr[MEM_AW+1:2]
MAX_WAIT, 3, LS grants tolerated while IF waits before IF is forced to win (>=1)

Ports:
clk  in  1  clock, all state changes on rising edge
nreset  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_WIDTH  fetch byte address (bits [1:0] ignored)
if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
if_rdata  out  DATA_WIDTH  fetched word
ls_req  in  1  load/store request, held until ls_ack
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_WIDTH  data byte address (bits [1:0] ignored)
ls_wdata  in  DATA_WIDTH  store data
ls_be  in  4  store byte enables
ls_ack  out  1  one-cycle pulse; access complete, ls_rdata valid for loads
ls_rdata  out  DATA_WIDTH  loaded word
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  MEM_AW  memory word address
mem_wdata  out  DATA_WIDTH  memory write data
mem_be  out  4  memory byte enables
mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en sampled
grant_owner  out  2  debug: 00 none, 01 IF, 10 LS (current RESP owner)

Behaviour:
- States: IDLE, RESP_IF, RESP_LS. The state register and wait counter are reset asynchronously to IDLE and 0.
- IDLE, no request: mem_en=0, mem_we=0, acks 0, stay in IDLE.
- IDLE, request present: select a winner combinationally and drive mem_en=1 and the winner's mem_addr this cycle. Next edge goes to RESP_<winner>.
- Winner selection: LS wins if ls_req=1 and (if_req=0 or if_wait<MAX_WAIT). Otherwise IF wins if if_req=1.
- IF issue: mem_we=0, mem_be=4'b1111, mem_wdata=0.
- LS issue: mem_we=ls_we, mem_be = ls_we ? ls_be : 4'b1111, mem_wdata=ls_wdata.
- RESP_X: x_ack=1 for exactly one cycle. mem_en=0. Next edge always returns to IDLE. No issue occurs in RESP.
- Read data: if_rdata=mem_rdata and ls_rdata=mem_rdata, combinational pass-through. Valid only while the matching ack is high. ls_rdata is don't-care on store acks.
- Latency and throughput: request sampled in IDLE at cycle T gives ack at T+1. Maximum rate is one access per 2 cycles.
- Requester rule: req is sampled in IDLE only. A req still high in the cycle after its ack is a new request. Address and data must be stable from req rise through ack.
- Requests arriving during RESP are held by the requester and arbitrated in the following IDLE.
- if_wait counter, width $clog2(MAX_WAIT+1):
  - Increments, saturating at MAX_WAIT, on each edge leaving IDLE with an LS grant while if_req=1.
  - Clears on any IF grant, and on any edge with if_req=0.
- grant_owner: 01 in RESP_IF, 10 in RESP_LS, 00 in IDLE.
- Reset values:
  - if_ack=0, ls_ack=0, grant_owner=00, mem_we=0.
  - While nreset=0, mem_en=0 and mem_we=0 are forced regardless of req.
  - mem_addr, mem_wdata and mem_be are don't-care while mem_en=0.
- Reset mid-operation: asserting nreset in RESP_X drops x_ack immediately (asynchronous). The access is abandoned and the counter is cleared. The requester must re-issue after release.
- Arithmetic: address bits above MEM_AW+1 are ignored (wrap within memory). No alignment checking.

Test Plan:
- IF-only: memory word 1 = 0xE0822001; if_req held high with if_addr=0x4.
  -> mem_en=1 and mem_addr=1 in cycle T; if_ack=1 and if_rdata=0xE0822001 at T+1; repeated acks at T+1, T+3, T+5; mem_we never 1.
- Simultaneous request: if_req=ls_req=1 in the same IDLE cycle, ls_we=0, ls_addr=0x10.
  -> LS granted first (mem_addr=4, grant_owner=10, ls_ack next cycle); IF issued in the following IDLE.
- Starvation, MAX_WAIT=3: ls_req held high continuously, if_req high.
  -> LS acks three times, then the fourth grant goes to IF; then LS again; the pattern repeats LS,LS,LS,IF.
- Store with byte enables: word 4 = 0x11223344; LS store addr=0x10, wdata=0xAABBCCDD, be=0011; then a load from 0x10.
  -> mem_we=1 for one cycle with mem_be=0011; the load returns 0x1122CCDD.
- Reset mid-op: nreset dropped during RESP_LS.
  -> ls_ack=0, mem_en=0, grant_owner=00 immediately, with no clock edge required; after release with no requests, the block stays in IDLE and if_wait=0.
